// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op bit indices, FSM states,
// bus size codes and the masks/helpers used to classify an op vector.
package mem_pkg;

    localparam int MEM_OP_W = 12;

    localparam int OP_LW  = 0;
    localparam int OP_SW  = 1;
    localparam int OP_LB  = 2;
    localparam int OP_LBU = 3;
    localparam int OP_LH  = 4;
    localparam int OP_LHU = 5;
    localparam int OP_LWL = 6;
    localparam int OP_LWR = 7;
    localparam int OP_SB  = 8;
    localparam int OP_SH  = 9;
    localparam int OP_SWL = 10;
    localparam int OP_SWR = 11;

    localparam logic [MEM_OP_W-1:0] LOAD_MASK    = 12'h0FD;
    localparam logic [MEM_OP_W-1:0] STORE_MASK   = 12'hF02;
    localparam logic [MEM_OP_W-1:0] WORD_AL_MASK = 12'hCC0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    function automatic size_t size_of(input logic [MEM_OP_W-1:0] op);
        if (op[OP_LB] || op[OP_LBU] || op[OP_SB]) begin
            return SIZE_BYTE;
        end else if (op[OP_LH] || op[OP_LHU] || op[OP_SH]) begin
            return SIZE_HALF;
        end
        return SIZE_WORD;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: selects, extends or merges the returned
// word with the old register value according to the load type and address.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0]         rdata,
    input  logic [31:0]         rt,
    input  logic [1:0]          addr_lo,
    input  logic [MEM_OP_W-1:0] mem_inst,
    output logic [31:0]         result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Word loads and all store bits fall through to the raw word.
    logic unused_bits;
    assign unused_bits = ^{mem_inst[OP_LW], mem_inst[OP_SW], mem_inst[OP_SB],
                           mem_inst[OP_SH], mem_inst[OP_SWL], mem_inst[OP_SWR]};

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;

        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        if (mem_inst[OP_LB]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (mem_inst[OP_LBU]) begin
            result = {24'h0, byte_sel};
        end else if (mem_inst[OP_LH]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (mem_inst[OP_LHU]) begin
            result = {16'h0, half_sel};
        end else if (mem_inst[OP_LWL]) begin
            case (addr_lo)
                2'd0: result = {rdata[7:0],  rt[23:0]};
                2'd1: result = {rdata[15:0], rt[15:0]};
                2'd2: result = {rdata[23:0], rt[7:0]};
                default: result = rdata;
            endcase
        end else if (mem_inst[OP_LWR]) begin
            case (addr_lo)
                2'd1: result = {rt[31:24], rdata[31:8]};
                2'd2: result = {rt[31:16], rdata[31:16]};
                2'd3: result = {rt[31:8],  rdata[31:24]};
                default: result = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_load_stage.sv
// Memory-access pipeline stage: captures one op, drives a single request on
// the split addr/data handshake bus, aligns load data and hands the result on.
module mem_load_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_INST_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_valid,
    output logic                  in_allowin,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [3:0]            in_wen,
    input  logic [31:0]           in_wdata,
    input  logic [MEM_INST_W-1:0] in_mem_inst,
    input  logic [31:0]           in_rt,
    input  logic [31:0]           in_alu_result,
    input  logic                  in_gr_we,
    input  logic [4:0]            in_dest,
    input  logic                  in_ex,
    input  logic                  flush,

    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [3:0]            data_wstrb,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,

    output logic                  out_valid,
    input  logic                  out_allowin,
    output logic                  out_gr_we,
    output logic [4:0]            out_dest,
    output logic [31:0]           out_result
);

    state_t                state_q, state_d;

    size_t                 size_q;
    logic                  wr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            addr_lo_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;
    logic [MEM_INST_W-1:0] mem_q;
    logic [31:0]           rt_q;
    logic [31:0]           alu_q;
    logic                  gr_we_q;
    logic [4:0]            dest_q;
    logic [31:0]           result_q;

    logic                  capture;
    logic                  in_is_mem;
    logic                  in_is_store;
    logic                  in_word_al;
    logic                  go_bus;
    logic                  is_load_q;
    logic                  take_data;
    logic [31:0]           aligned;

    assign in_is_mem   = |in_mem_inst;
    assign in_is_store = |(in_mem_inst & STORE_MASK);
    assign in_word_al  = |(in_mem_inst & WORD_AL_MASK);
    assign go_bus      = in_is_mem && !in_ex;
    assign capture     = (state_q == ST_IDLE) && in_valid && !flush;
    assign is_load_q   = |(mem_q & LOAD_MASK);
    assign take_data   = (state_q == ST_WAIT) && data_data_ok && !flush;

    load_align u_load_align (
        .rdata    (data_rdata),
        .rt       (rt_q),
        .addr_lo  (addr_lo_q),
        .mem_inst (mem_q),
        .result   (aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_allowin = 1'b0;
        data_req   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_allowin = 1'b1;
                if (capture) begin
                    state_d = go_bus ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                // An accepted address still owes a data beat, so it must drain.
                if (flush) begin
                    state_d = data_addr_ok ? ST_DRAIN : ST_IDLE;
                end else if (data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (flush || out_allowin) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q    <= SIZE_BYTE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            addr_lo_q <= 2'b00;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            mem_q     <= '0;
            rt_q      <= 32'h0;
            alu_q     <= 32'h0;
            gr_we_q   <= 1'b0;
            dest_q    <= 5'd0;
            result_q  <= 32'h0;
        end else begin
            if (capture) begin
                size_q    <= size_of(in_mem_inst);
                wr_q      <= in_is_store;
                addr_q    <= in_word_al ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;
                addr_lo_q <= in_addr[1:0];
                wstrb_q   <= in_is_store ? in_wen : 4'b0000;
                wdata_q   <= in_wdata;
                mem_q     <= in_mem_inst;
                rt_q      <= in_rt;
                alu_q     <= in_alu_result;
                gr_we_q   <= in_gr_we && !in_ex;
                dest_q    <= in_dest;
                if (!go_bus) begin
                    result_q <= in_alu_result;
                end
            end
            if (take_data) begin
                result_q <= is_load_q ? aligned : alu_q;
            end
        end
    end

    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign out_gr_we  = gr_we_q;
    assign out_dest   = dest_q;
    assign out_result = result_q;

endmodule
